// File: rtl/mux2_rr_arbiter_if.sv
// Bundle of the two requester channels and the output channel of mux2_rr_arbiter.
// The master side is the producers plus the consumer; the slave side is the arbiter.
interface mux2_rr_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] in_0;
  logic         in_0_valid;
  logic         in_0_ready;
  logic [N-1:0] in_1;
  logic         in_1_valid;
  logic         in_1_ready;
  logic [N-1:0] out;
  logic         out_valid;
  logic         out_ready;
  logic         sel;

  modport master (
    output in_0, in_0_valid, in_1, in_1_valid, out_ready,
    input  in_0_ready, in_1_ready, out, out_valid, sel
  );

  modport slave (
    input  in_0, in_0_valid, in_1, in_1_valid, out_ready,
    output in_0_ready, in_1_ready, out, out_valid, sel
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin (or fixed-priority) arbiter that steers a 2:1 mux
// into a one-entry registered output stage and reports the winning source.
module mux2_rr_arbiter #(
  parameter int N         = 4,
  parameter bit PRIO_MODE = 1'b0
) (
  input logic               clk,
  input logic               rst,
  mux2_rr_arbiter_if.slave  bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t       state;
  state_t       state_next;
  logic [N-1:0] out_q;
  logic         sel_q;
  logic         load;
  logic         grant;
  logic         accept;
  logic [N-1:0] mux_word;

  assign bus.out       = out_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = (state == FULL);

  assign load = (state == EMPTY) || bus.out_ready;

  // sel doubles as the round-robin pointer: on a tie the other source wins.
  always_comb begin
    grant = 1'b0;
    if (bus.in_0_valid && bus.in_1_valid) begin
      grant = PRIO_MODE ? 1'b0 : ~sel_q;
    end else if (bus.in_1_valid) begin
      grant = 1'b1;
    end
  end

  // Readies stay low during reset so nothing is accepted in the release cycle.
  assign bus.in_0_ready = !rst && load && bus.in_0_valid && (grant == 1'b0);
  assign bus.in_1_ready = !rst && load && bus.in_1_valid && (grant == 1'b1);
  assign accept         = bus.in_0_ready || bus.in_1_ready;
  assign mux_word       = grant ? bus.in_1 : bus.in_0;

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = FULL;
      FULL:  if (bus.out_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      out_q <= '0;
      sel_q <= 1'b1;
    end else begin
      state <= state_next;
      if (accept) begin
        out_q <= mux_word;
        sel_q <= grant;
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench: one round-robin and one fixed-priority arbiter driven with the
// same vector table, followed by a hand-written asynchronous reset sequence.
module tb_mux2_rr_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mux2_rr_arbiter_if #(.N(4)) bus_rr ();
  mux2_rr_arbiter_if #(.N(4)) bus_pr ();

  mux2_rr_arbiter #(.N(4), .PRIO_MODE(1'b0)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_rr.slave)
  );

  mux2_rr_arbiter #(.N(4), .PRIO_MODE(1'b1)) dut_pr (
    .clk (clk),
    .rst (rst),
    .bus (bus_pr.slave)
  );

  typedef struct {
    logic       v0;
    logic [3:0] d0;
    logic       v1;
    logic [3:0] d1;
    logic       ordy;
    logic       rr_r0;
    logic       rr_r1;
    logic [3:0] rr_out;
    logic       rr_ov;
    logic       rr_sel;
    logic       pr_r0;
    logic       pr_r1;
    logic [3:0] pr_out;
    logic       pr_ov;
    logic       pr_sel;
  } vec_t;

  vec_t vecs [15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic v0, input logic [3:0] d0,
                                input logic v1, input logic [3:0] d1,
                                input logic ordy);
    bus_rr.in_0_valid = v0;  bus_pr.in_0_valid = v0;
    bus_rr.in_0       = d0;  bus_pr.in_0       = d0;
    bus_rr.in_1_valid = v1;  bus_pr.in_1_valid = v1;
    bus_rr.in_1       = d1;  bus_pr.in_1       = d1;
    bus_rr.out_ready  = ordy; bus_pr.out_ready = ordy;
  endtask

  task automatic check_output(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_regs(input string tag,
                            input logic [3:0] rr_out, input logic rr_ov, input logic rr_sel,
                            input logic [3:0] pr_out, input logic pr_ov, input logic pr_sel);
    check_output({tag, " rr.out"},       {4'h0, bus_rr.out},       {4'h0, rr_out});
    check_output({tag, " rr.out_valid"}, {7'h0, bus_rr.out_valid}, {7'h0, rr_ov});
    check_output({tag, " rr.sel"},       {7'h0, bus_rr.sel},       {7'h0, rr_sel});
    check_output({tag, " pr.out"},       {4'h0, bus_pr.out},       {4'h0, pr_out});
    check_output({tag, " pr.out_valid"}, {7'h0, bus_pr.out_valid}, {7'h0, pr_ov});
    check_output({tag, " pr.sel"},       {7'h0, bus_pr.sel},       {7'h0, pr_sel});
  endtask

  task automatic check_readies(input string tag,
                               input logic rr_r0, input logic rr_r1,
                               input logic pr_r0, input logic pr_r1);
    check_output({tag, " rr.in_0_ready"}, {7'h0, bus_rr.in_0_ready}, {7'h0, rr_r0});
    check_output({tag, " rr.in_1_ready"}, {7'h0, bus_rr.in_1_ready}, {7'h0, rr_r1});
    check_output({tag, " pr.in_0_ready"}, {7'h0, bus_pr.in_0_ready}, {7'h0, pr_r0});
    check_output({tag, " pr.in_1_ready"}, {7'h0, bus_pr.in_1_ready}, {7'h0, pr_r1});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // v0 d0 v1 d1 ordy | rr: r0 r1 out ov sel | pr: r0 r1 out ov sel
    vecs[0]  = '{1'b1, 4'h6, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0, 4'h6, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 4'hF, 1'b1, 4'h9, 1'b1, 1'b0, 1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'hF, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'hF, 1'b1, 4'h9, 1'b1, 1'b0, 1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'hF, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'h0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h1, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 4'h2, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 4'h2, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 4'h2, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 4'h2, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'h0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 4'h7, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h7, 1'b1, 1'b0, 1'b1, 1'b0, 4'h7, 1'b1, 1'b0};

    rst = 1'b1;
    apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    #1;
    check_regs("reset", 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      apply_stimulus(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy);
      #1;
      check_readies($sformatf("vec%0d", i), vecs[i].rr_r0, vecs[i].rr_r1,
                    vecs[i].pr_r0, vecs[i].pr_r1);
      @(posedge clk);
      #1;
      check_regs($sformatf("vec%0d", i), vecs[i].rr_out, vecs[i].rr_ov, vecs[i].rr_sel,
                 vecs[i].pr_out, vecs[i].pr_ov, vecs[i].pr_sel);
    end

    // Asynchronous reset in the middle of a cycle while the stage is full.
    @(negedge clk);
    apply_stimulus(1'b1, 4'hA, 1'b1, 4'hB, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_regs("async_rst", 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
    check_readies("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_regs("rst_held", 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_readies("post_rst", 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_regs("post_rst", 4'hA, 1'b1, 1'b0, 4'hA, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
